fp_cmp_resp: RTL and testbench

FP_CMP_RESP -- requirements
Module: fp_cmp_resp

---
 rtl/fp_cmp_resp_if.sv | 23 ++
 rtl/fp_cmp_resp.sv | 188 ++++++++++++++++++
 tb/tb_fp_cmp_resp.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_cmp_resp_if.sv
// Request/response bundle for the fixed-latency FP sign-inject / min-max / compare unit.
// Handshake: a request is taken on every rising clock edge where enable==1 (no backpressure);
// ready pulses for exactly one cycle LATENCY cycles later, and result/flags are 0 whenever ready==0.
interface fp_cmp_resp_if;
   logic        enable;
   logic [31:0] data1;
   logic [31:0] data2;
   logic [1:0]  op_sel;
   logic [2:0]  rm;
   logic [31:0] result;
   logic [4:0]  flags;
   logic        ready;

   modport master (
      output enable, data1, data2, op_sel, rm,
      input  result, flags, ready
   );

   modport slave (
      input  enable, data1, data2, op_sel, rm,
      output result, flags, ready
   );
endinterface

// File: rtl/fp_cmp_resp.sv
// Fixed-latency binary32 sign-inject, min/max and compare unit (RISC-V F semantics).
// Operands are captured on enable, evaluated in one stage, then delayed through a valid-tagged pipe.
module fp_cmp_resp #(
   parameter int LATENCY = 3
) (
   input  logic         clock,
   input  logic         reset,
   fp_cmp_resp_if.slave bus
);

   localparam logic [1:0]  OP_SGNJ   = 2'd0;
   localparam logic [1:0]  OP_MINMAX = 2'd1;
   localparam logic [1:0]  OP_CMP    = 2'd2;
   localparam logic [31:0] QNAN      = 32'h7FC0_0000;
   localparam logic [4:0]  FLAG_NV   = 5'h10;

   // ---------------------------------------------------------------
   // Operand capture stage
   // ---------------------------------------------------------------
   logic        vld0_q, vld0_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [1:0]  op_q, op_d;
   logic [2:0]  rm_q, rm_d;

   always_comb begin
      vld0_d = bus.enable;
      a_d    = a_q;
      b_d    = b_q;
      op_d   = op_q;
      rm_d   = rm_q;
      if (bus.enable) begin
         a_d  = bus.data1;
         b_d  = bus.data2;
         op_d = bus.op_sel;
         rm_d = bus.rm;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         vld0_q <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= '0;
         rm_q   <= '0;
      end else begin
         vld0_q <= vld0_d;
         a_q    <= a_d;
         b_q    <= b_d;
         op_q   <= op_d;
         rm_q   <= rm_d;
      end
   end

   // ---------------------------------------------------------------
   // Operand classification and ordering
   // ---------------------------------------------------------------
   logic a_s, b_s;
   logic a_nan, b_nan, a_snan, b_snan;
   logic nan_any, snan_any;
   logic both_zero, mag_lt, mag_eq, mag_gt;
   logic ord_lt, ord_eq, mm_lt;

   assign a_s      = a_q[31];
   assign b_s      = b_q[31];
   assign a_nan    = (&a_q[30:23]) & (|a_q[22:0]);
   assign b_nan    = (&b_q[30:23]) & (|b_q[22:0]);
   assign a_snan   = a_nan & ~a_q[22];
   assign b_snan   = b_nan & ~b_q[22];
   assign nan_any  = a_nan | b_nan;
   assign snan_any = a_snan | b_snan;

   assign both_zero = ~(|a_q[30:0]) & ~(|b_q[30:0]);
   assign mag_lt    = a_q[30:0] < b_q[30:0];
   assign mag_eq    = a_q[30:0] == b_q[30:0];
   assign mag_gt    = ~mag_lt & ~mag_eq;

   // Sign-magnitude order; for negatives a larger magnitude is the smaller value.
   always_comb begin
      ord_lt = 1'b0;
      if (a_s != b_s) begin
         ord_lt = a_s & ~both_zero;
      end else if (!a_s) begin
         ord_lt = mag_lt;
      end else begin
         ord_lt = mag_gt;
      end
   end

   assign ord_eq = (a_q == b_q) | both_zero;

   // min/max treats -0 as strictly below +0, so a sign difference alone decides.
   assign mm_lt = (a_s != b_s) ? a_s : (a_s ? mag_gt : mag_lt);

   // ---------------------------------------------------------------
   // Operation evaluation
   // ---------------------------------------------------------------
   logic [31:0] res_d;
   logic [4:0]  flg_d;

   always_comb begin
      res_d = '0;
      flg_d = '0;
      unique case (op_q)
         OP_SGNJ: begin
            unique case (rm_q)
               3'd0:    res_d = {b_s, a_q[30:0]};
               3'd1:    res_d = {~b_s, a_q[30:0]};
               3'd2:    res_d = {a_s ^ b_s, a_q[30:0]};
               default: flg_d = FLAG_NV;
            endcase
         end
         OP_MINMAX: begin
            if (rm_q == 3'd0 || rm_q == 3'd1) begin
               flg_d = snan_any ? FLAG_NV : 5'h00;
               if (a_nan && b_nan) begin
                  res_d = QNAN;
               end else if (a_nan) begin
                  res_d = b_q;
               end else if (b_nan) begin
                  res_d = a_q;
               end else if (rm_q == 3'd0) begin
                  res_d = mm_lt ? a_q : b_q;
               end else begin
                  res_d = mm_lt ? b_q : a_q;
               end
            end else begin
               flg_d = FLAG_NV;
            end
         end
         OP_CMP: begin
            unique case (rm_q)
               3'd0: begin
                  res_d = {31'd0, ~nan_any & (ord_lt | ord_eq)};
                  flg_d = nan_any ? FLAG_NV : 5'h00;
               end
               3'd1: begin
                  res_d = {31'd0, ~nan_any & ord_lt};
                  flg_d = nan_any ? FLAG_NV : 5'h00;
               end
               3'd2: begin
                  // Quiet equality: only signalling NaNs are invalid.
                  res_d = {31'd0, ~nan_any & ord_eq};
                  flg_d = snan_any ? FLAG_NV : 5'h00;
               end
               default: flg_d = FLAG_NV;
            endcase
         end
         default: flg_d = FLAG_NV;
      endcase
      if (!vld0_q) begin
         res_d = '0;
         flg_d = '0;
      end
   end

   // ---------------------------------------------------------------
   // Response delay pipe; empty slots carry zero payload
   // ---------------------------------------------------------------
   logic        vld_q [LATENCY];
   logic [31:0] res_q [LATENCY];
   logic [4:0]  flg_q [LATENCY];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            vld_q[i] <= 1'b0;
            res_q[i] <= '0;
            flg_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= vld0_q;
         res_q[0] <= res_d;
         flg_q[0] <= flg_d;
         for (int i = 1; i < LATENCY; i++) begin
            vld_q[i] <= vld_q[i-1];
            res_q[i] <= res_q[i-1];
            flg_q[i] <= flg_q[i-1];
         end
      end
   end

   assign bus.ready  = vld_q[LATENCY-1];
   assign bus.result = res_q[LATENCY-1];
   assign bus.flags  = flg_q[LATENCY-1];

endmodule

// File: tb/tb_fp_cmp_resp.sv
// Directed bench for fp_cmp_resp: per-feature tasks with hand-computed expectations.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_fp_cmp_resp;
  localparam int LAT = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fp_cmp_resp_if bus();

  fp_cmp_resp #(.LATENCY(LAT)) dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [2:0]  rm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [4:0]  flg;
  } vec_t;

  task automatic drive(input vec_t v);
    bus.enable = 1'b1;
    bus.op_sel = v.op;
    bus.rm     = v.rm;
    bus.data1  = v.a;
    bus.data2  = v.b;
  endtask

  task automatic idle();
    bus.enable = 1'b0;
    bus.op_sel = 2'd0;
    bus.rm     = 3'd0;
    bus.data1  = 32'h0;
    bus.data2  = 32'h0;
  endtask

  // Issues one request and samples one cycle before, at, and one cycle after the expected pulse.
  task automatic run_op(input vec_t v, output logic rdy, output logic [31:0] res,
                        output logic [4:0] flg, output logic [38:0] quiet);
    logic pre;
    @(negedge clk);
    drive(v);
    @(negedge clk);
    idle();
    repeat (LAT - 1) @(negedge clk);
    pre = bus.ready;
    @(negedge clk);
    rdy = bus.ready;
    res = bus.result;
    flg = bus.flags;
    @(negedge clk);
    quiet = {pre, bus.ready, bus.result, bus.flags};
  endtask

  task automatic run_table(input string name, input vec_t v[], input int n);
    logic        rdy;
    logic [31:0] res;
    logic [4:0]  flg;
    logic [38:0] quiet;
    for (int i = 0; i < n; i++) begin
      run_op(v[i], rdy, res, flg, quiet);
      n_vec++;
      if ({rdy, res, flg} !== {1'b1, v[i].res, v[i].flg}) begin
        n_err++;
        $display("FAIL %s[%0d]: got ready=%b result=%h flags=%h, expected ready=1 result=%h flags=%h",
                 name, i, rdy, res, flg, v[i].res, v[i].flg);
      end
      n_vec++;
      if (quiet !== 39'd0) begin
        n_err++;
        $display("FAIL %s_quiet[%0d]: got pre_ready=%b post_ready=%b post_result=%h post_flags=%h, expected all 0",
                 name, i, quiet[38], quiet[37], quiet[36:5], quiet[4:0]);
      end
    end
  endtask

  task automatic test_reset();
    idle();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.ready, bus.result, bus.flags} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_state: got ready=%b result=%h flags=%h, expected 0 0 0",
               bus.ready, bus.result, bus.flags);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++;
      if (bus.ready !== 1'b0) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: got ready=%b, expected 0", c, bus.ready);
      end
    end
  endtask

  task automatic test_sign_inject();
    vec_t v[5];
    v[0] = '{2'd0, 3'd2, 32'hBF800000, 32'h80000000, 32'h3F800000, 5'h00};
    v[1] = '{2'd0, 3'd1, 32'h3F800000, 32'h3F800000, 32'hBF800000, 5'h00};
    v[2] = '{2'd0, 3'd0, 32'h3F800000, 32'h80000000, 32'hBF800000, 5'h00};
    v[3] = '{2'd0, 3'd0, 32'h7FC00001, 32'h80000000, 32'hFFC00001, 5'h00};
    v[4] = '{2'd0, 3'd1, 32'hFF800001, 32'h00000000, 32'hFF800001, 5'h00};
    run_table("sgnj", v, 5);
  endtask

  task automatic test_compare();
    vec_t v[11];
    v[0]  = '{2'd2, 3'd2, 32'h3F800000, 32'h3F800000, 32'h00000001, 5'h00};
    v[1]  = '{2'd2, 3'd1, 32'h7FC00000, 32'h3F800000, 32'h00000000, 5'h10};
    v[2]  = '{2'd2, 3'd2, 32'h7FC00000, 32'h3F800000, 32'h00000000, 5'h00};
    v[3]  = '{2'd2, 3'd1, 32'hBF800000, 32'h3F800000, 32'h00000001, 5'h00};
    v[4]  = '{2'd2, 3'd0, 32'h00000000, 32'h80000000, 32'h00000001, 5'h00};
    v[5]  = '{2'd2, 3'd1, 32'hC0000000, 32'hBF800000, 32'h00000001, 5'h00};
    v[6]  = '{2'd2, 3'd1, 32'hBF800000, 32'hC0000000, 32'h00000000, 5'h00};
    v[7]  = '{2'd2, 3'd0, 32'h7F800000, 32'h3F800000, 32'h00000000, 5'h00};
    v[8]  = '{2'd2, 3'd2, 32'h7F800001, 32'h3F800000, 32'h00000000, 5'h10};
    v[9]  = '{2'd2, 3'd0, 32'h7F800001, 32'h3F800000, 32'h00000000, 5'h10};
    v[10] = '{2'd2, 3'd1, 32'h3F800000, 32'h3F800000, 32'h00000000, 5'h00};
    run_table("cmp", v, 11);
  endtask

  task automatic test_minmax();
    vec_t v[8];
    v[0] = '{2'd1, 3'd0, 32'h80000000, 32'h00000000, 32'h80000000, 5'h00};
    v[1] = '{2'd1, 3'd1, 32'h80000000, 32'h00000000, 32'h00000000, 5'h00};
    v[2] = '{2'd1, 3'd1, 32'h7F800001, 32'h40000000, 32'h40000000, 5'h10};
    v[3] = '{2'd1, 3'd0, 32'h7FC00000, 32'h7FC00001, 32'h7FC00000, 5'h00};
    v[4] = '{2'd1, 3'd0, 32'h7FC00000, 32'h3F800000, 32'h3F800000, 5'h00};
    v[5] = '{2'd1, 3'd1, 32'hBF800000, 32'hC0000000, 32'hBF800000, 5'h00};
    v[6] = '{2'd1, 3'd0, 32'h3F800000, 32'hC0000000, 32'hC0000000, 5'h00};
    v[7] = '{2'd1, 3'd0, 32'h7F800001, 32'h7FC00000, 32'h7FC00000, 5'h10};
    run_table("minmax", v, 8);
  endtask

  task automatic test_illegal();
    vec_t v[5];
    v[0] = '{2'd3, 3'd0, 32'h3F800000, 32'h3F800000, 32'h00000000, 5'h10};
    v[1] = '{2'd0, 3'd3, 32'h3F800000, 32'hBF800000, 32'h00000000, 5'h10};
    v[2] = '{2'd1, 3'd2, 32'h3F800000, 32'h40000000, 32'h00000000, 5'h10};
    v[3] = '{2'd2, 3'd3, 32'h3F800000, 32'h3F800000, 32'h00000000, 5'h10};
    v[4] = '{2'd2, 3'd7, 32'h3F800000, 32'h3F800000, 32'h00000000, 5'h10};
    run_table("illegal", v, 5);
  endtask

  task automatic test_back_to_back();
    vec_t v[4];
    v[0] = '{2'd2, 3'd0, 32'h3F800000, 32'h40000000, 32'h00000001, 5'h00};
    v[1] = '{2'd2, 3'd1, 32'h40000000, 32'h3F800000, 32'h00000000, 5'h00};
    v[2] = '{2'd2, 3'd2, 32'h80000000, 32'h00000000, 32'h00000001, 5'h00};
    v[3] = '{2'd1, 3'd1, 32'h3F800000, 32'h40000000, 32'h40000000, 5'h00};
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        n_vec++;
        if (bus.ready !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_early[%0d]: got ready=%b, expected 0", c, bus.ready);
        end
      end
      if (c >= 4 && c <= 7) begin
        n_vec++;
        if ({bus.ready, bus.result, bus.flags} !== {1'b1, v[c-4].res, v[c-4].flg}) begin
          n_err++;
          $display("FAIL b2b[%0d]: got ready=%b result=%h flags=%h, expected ready=1 result=%h flags=%h",
                   c - 4, bus.ready, bus.result, bus.flags, v[c-4].res, v[c-4].flg);
        end
      end
      if (c == 8) begin
        n_vec++;
        if ({bus.ready, bus.result, bus.flags} !== 38'd0) begin
          n_err++;
          $display("FAIL b2b_tail: got ready=%b result=%h flags=%h, expected 0 0 0",
                   bus.ready, bus.result, bus.flags);
        end
      end
      if (c < 4) drive(v[c]);
      else idle();
    end
  endtask

  task automatic test_gap();
    vec_t        g[2];
    logic [37:0] exp_out[4];
    g[0] = '{2'd2, 3'd2, 32'h3F800000, 32'h3F800000, 32'h00000001, 5'h00};
    g[1] = '{2'd0, 3'd1, 32'h3F800000, 32'h3F800000, 32'hBF800000, 5'h00};
    exp_out[0] = {1'b1, 32'h00000001, 5'h00};
    exp_out[1] = 38'd0;
    exp_out[2] = {1'b1, 32'hBF800000, 5'h00};
    exp_out[3] = 38'd0;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        n_vec++;
        if ({bus.ready, bus.result, bus.flags} !== exp_out[c-4]) begin
          n_err++;
          $display("FAIL gap[%0d]: got ready=%b result=%h flags=%h, expected ready=%b result=%h flags=%h",
                   c - 4, bus.ready, bus.result, bus.flags,
                   exp_out[c-4][37], exp_out[c-4][36:5], exp_out[c-4][4:0]);
        end
      end
      if (c == 0) drive(g[0]);
      else if (c == 2) drive(g[1]);
      else idle();
    end
  endtask

  task automatic check_silent(input string name, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      n_vec++;
      if ({bus.ready, bus.result, bus.flags} !== 38'd0) begin
        n_err++;
        $display("FAIL %s[%0d]: got ready=%b result=%h flags=%h, expected 0 0 0",
                 name, c, bus.ready, bus.result, bus.flags);
      end
    end
  endtask

  task automatic test_reset_in_flight();
    vec_t        v[3];
    logic        rdy;
    logic [31:0] res;
    logic [4:0]  flg;
    logic [38:0] quiet;
    v[0] = '{2'd2, 3'd2, 32'h3F800000, 32'h3F800000, 32'h00000001, 5'h00};
    v[1] = '{2'd0, 3'd1, 32'h3F800000, 32'h3F800000, 32'hBF800000, 5'h00};
    v[2] = '{2'd3, 3'd0, 32'h3F800000, 32'h3F800000, 32'h00000000, 5'h10};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(v[c]);
    end
    @(negedge clk);
    idle();
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.ready, bus.result, bus.flags} !== 38'd0) begin
      n_err++;
      $display("FAIL rst_flight_now: got ready=%b result=%h flags=%h, expected 0 0 0",
               bus.ready, bus.result, bus.flags);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_silent("rst_flight_discard", 6);
    run_op(v[1], rdy, res, flg, quiet);
    n_vec++;
    if ({rdy, res, flg} !== {1'b1, 32'hBF800000, 5'h00} || quiet !== 39'd0) begin
      n_err++;
      $display("FAIL rst_flight_first: got ready=%b result=%h flags=%h quiet=%h, expected ready=1 result=bf800000 flags=00 quiet=0",
               rdy, res, flg, quiet);
    end
  endtask

  task automatic test_reset_during_ready();
    vec_t v[2];
    v[0] = '{2'd0, 3'd1, 32'h3F800000, 32'h3F800000, 32'hBF800000, 5'h00};
    v[1] = '{2'd1, 3'd1, 32'h7F800001, 32'h40000000, 32'h40000000, 5'h10};
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c < 2) drive(v[c]);
      else idle();
    end
    n_vec++;
    if ({bus.ready, bus.result, bus.flags} !== {1'b1, 32'hBF800000, 5'h00}) begin
      n_err++;
      $display("FAIL rst_pulse_pre: got ready=%b result=%h flags=%h, expected ready=1 result=bf800000 flags=00",
               bus.ready, bus.result, bus.flags);
    end
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.ready, bus.result, bus.flags} !== 38'd0) begin
      n_err++;
      $display("FAIL rst_pulse_async: got ready=%b result=%h flags=%h, expected 0 0 0",
               bus.ready, bus.result, bus.flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_silent("rst_pulse_discard", 6);
  endtask

  initial begin
    idle();
    test_reset();
    test_sign_inject();
    test_compare();
    test_minmax();
    test_illegal();
    test_back_to_back();
    test_gap();
    test_reset_in_flight();
    test_reset_during_ready();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
